// File: rtl/cart_mem_loader.sv
// Cartridge/ROM loader: muxes an erase engine, an ioctl download port and the
// CPU onto a single memory write port, and stretches the core reset around loads.
module cart_mem_loader #(
    parameter int                               ADDR_W      = 16,
    parameter int                               DATA_W      = 8,
    parameter int                               NUM_REGIONS = 2,
    parameter logic [NUM_REGIONS*ADDR_W-1:0]     REGION_BASE = {16'hC000, 16'h0000},
    parameter logic [NUM_REGIONS*(ADDR_W+1)-1:0] REGION_SIZE = {17'h04000, 17'h10000},
    parameter logic [ADDR_W-1:0]                ERASE_START = 16'h7000,
    parameter logic [ADDR_W-1:0]                ERASE_END   = 16'hFFFF,
    parameter logic [DATA_W-1:0]                FILL        = 8'h00,
    parameter logic [7:0]                       RESET_HOLD  = 8'd255
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ext_reset,
    input  logic              ioctl_download,
    input  logic              ioctl_wr,
    input  logic [7:0]        ioctl_index,
    input  logic [24:0]       ioctl_addr,
    input  logic [DATA_W-1:0] ioctl_dout,
    input  logic              erase_req,
    input  logic [ADDR_W-1:0] cpu_a,
    input  logic              cpu_we_n,
    input  logic [DATA_W-1:0] cpu_do,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_d,
    output logic              erasing,
    output logic              busy,
    output logic              core_reset,
    output logic              load_err
);

    localparam int CMP_W = (ADDR_W + 1 > 25) ? ADDR_W + 1 : 25;

    typedef enum logic [1:0] {S_IDLE, S_PEND, S_WRITE, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ecnt_q, ecnt_d;
    logic              erase_hist_q;
    logic              dl_hist_q;
    logic              load_err_q, load_err_d;
    logic [7:0]        hold_q, hold_d;
    logic [1:0]        rst_sync_q;

    logic              erase_rise;
    logic              rst_done;
    logic              dl_start;
    logic              bad_wr;
    logic              idx_ok;
    logic              addr_ok;
    logic              dl_valid;
    logic [ADDR_W-1:0] base_sel;
    logic [ADDR_W:0]   size_sel;
    logic [ADDR_W-1:0] dl_addr;

    logic [ADDR_W-1:0] base_arr [NUM_REGIONS];
    logic [ADDR_W:0]   size_arr [NUM_REGIONS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGIONS; gi++) begin : g_region
            assign base_arr[gi] = REGION_BASE[gi*ADDR_W +: ADDR_W];
            assign size_arr[gi] = REGION_SIZE[gi*(ADDR_W+1) +: ADDR_W+1];
        end
    endgenerate

    always_comb begin
        base_sel = '0;
        size_sel = '0;
        idx_ok   = 1'b0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (ioctl_index == 8'(i)) begin
                base_sel = base_arr[i];
                size_sel = size_arr[i];
                idx_ok   = 1'b1;
            end
        end
    end

    assign addr_ok    = CMP_W'(ioctl_addr) < CMP_W'(size_sel);
    assign dl_valid   = idx_ok & addr_ok;
    assign dl_addr    = base_sel + ioctl_addr[ADDR_W-1:0];
    assign erase_rise = erase_req & ~erase_hist_q;
    assign rst_done   = rst_sync_q[1];
    assign dl_start   = ioctl_download & ~dl_hist_q;
    // Writes landing while the erase owns the port are dropped and flagged too.
    assign bad_wr     = ioctl_download & ioctl_wr & (erasing | ~dl_valid);

    assign erasing    = (state_q == S_WRITE) || (state_q == S_DONE);
    assign busy       = erasing | ioctl_download | (state_q == S_PEND);
    assign core_reset = ~rst_done | ext_reset | ioctl_download | erasing | (hold_q != 8'd0);
    assign load_err   = load_err_q;

    always_comb begin
        mem_a  = cpu_a;
        mem_d  = cpu_do;
        mem_we = ~cpu_we_n;
        if (erasing) begin
            mem_a  = ecnt_q;
            mem_d  = FILL;
            mem_we = (state_q == S_WRITE);
        end else if (ioctl_download) begin
            mem_a  = dl_addr;
            mem_d  = ioctl_dout;
            mem_we = ioctl_wr & dl_valid;
        end
    end

    always_comb begin
        state_d = state_q;
        ecnt_d  = ecnt_q;
        case (state_q)
            S_IDLE: begin
                ecnt_d = ERASE_START;
                if (erase_rise) state_d = ioctl_download ? S_PEND : S_WRITE;
            end
            S_PEND: begin
                if (!ioctl_download) state_d = S_WRITE;
            end
            S_WRITE: begin
                // Stop on the last address instead of incrementing, so an
                // all-ones end address never wraps back to zero.
                if (ecnt_q == ERASE_END) state_d = S_DONE;
                else                     ecnt_d  = ecnt_q + ADDR_W'(1);
            end
            S_DONE: begin
                state_d = S_IDLE;
                ecnt_d  = ERASE_START;
            end
            default: begin
                state_d = S_IDLE;
                ecnt_d  = ERASE_START;
            end
        endcase
    end

    always_comb begin
        load_err_d = dl_start ? bad_wr : (load_err_q | bad_wr);
        hold_d     = hold_q;
        if (!rst_done || ext_reset || ioctl_download || erasing) hold_d = RESET_HOLD;
        else if (hold_q != 8'd0)                                  hold_d = hold_q - 8'd1;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            ecnt_q       <= ERASE_START;
            erase_hist_q <= 1'b1;
            dl_hist_q    <= 1'b0;
            load_err_q   <= 1'b0;
            hold_q       <= RESET_HOLD;
            rst_sync_q   <= 2'b00;
        end else begin
            state_q      <= state_d;
            ecnt_q       <= ecnt_d;
            erase_hist_q <= erase_req;
            dl_hist_q    <= ioctl_download;
            load_err_q   <= load_err_d;
            hold_q       <= hold_d;
            rst_sync_q   <= {rst_sync_q[0], 1'b1};
        end
    end

endmodule

// File: tb/tb_cart_mem_loader.sv
// Directed bench for cart_mem_loader: download mapping/limits, erase sweep,
// pending erase, reset abort and reset stretching.
module tb_cart_mem_loader;

    logic        clk_sys = 1'b0;
    logic        reset_n, ext_reset, ioctl_download, ioctl_wr, erase_req, cpu_we_n;
    logic [7:0]  ioctl_index, ioctl_dout, cpu_do, mem_d;
    logic [24:0] ioctl_addr;
    logic [15:0] cpu_a, mem_a;
    logic        mem_we, erasing, busy, core_reset, load_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_sys = ~clk_sys;

    cart_mem_loader dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .ext_reset(ext_reset),
        .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr), .ioctl_index(ioctl_index),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .erase_req(erase_req),
        .cpu_a(cpu_a), .cpu_we_n(cpu_we_n), .cpu_do(cpu_do),
        .mem_a(mem_a), .mem_we(mem_we), .mem_d(mem_d),
        .erasing(erasing), .busy(busy), .core_reset(core_reset), .load_err(load_err)
    );

    typedef struct {
        logic [7:0]  idx;
        logic [24:0] addr;
        logic [7:0]  dout;
        logic        wr;
        logic [15:0] exp_a;
        logic        exp_we;
        logic        exp_err;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    initial begin
        int n;
        int wcount;
        int bad;
        int exp_addr;
        int we_seen;
        int er_seen;

        vecs[0]  = '{8'd1, 25'h00000, 8'hA0, 1'b1, 16'hC000, 1'b1, 1'b0};
        vecs[1]  = '{8'd1, 25'h00001, 8'hA1, 1'b1, 16'hC001, 1'b1, 1'b0};
        vecs[2]  = '{8'd1, 25'h00002, 8'hA2, 1'b1, 16'hC002, 1'b1, 1'b0};
        vecs[3]  = '{8'd1, 25'h00003, 8'hA3, 1'b1, 16'hC003, 1'b1, 1'b0};
        vecs[4]  = '{8'd0, 25'h01234, 8'h55, 1'b1, 16'h1234, 1'b1, 1'b0};
        vecs[5]  = '{8'd0, 25'h0FFFF, 8'h66, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[6]  = '{8'd1, 25'h03FFF, 8'h77, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[7]  = '{8'd1, 25'h00005, 8'h88, 1'b0, 16'hC005, 1'b0, 1'b0};
        vecs[8]  = '{8'd1, 25'h04000, 8'h99, 1'b1, 16'h0000, 1'b0, 1'b0};
        vecs[9]  = '{8'd5, 25'h00000, 8'hAA, 1'b1, 16'h0000, 1'b0, 1'b1};
        vecs[10] = '{8'd1, 25'h10000, 8'hBB, 1'b1, 16'h0000, 1'b0, 1'b1};
        vecs[11] = '{8'd0, 25'h10000, 8'hCC, 1'b1, 16'h0000, 1'b0, 1'b1};

        reset_n = 1'b0; ext_reset = 1'b0; ioctl_download = 1'b1; ioctl_wr = 1'b0;
        ioctl_index = 8'd0; ioctl_addr = '0; ioctl_dout = 8'h00; erase_req = 1'b1;
        cpu_a = 16'h0000; cpu_we_n = 1'b1; cpu_do = 8'h00;

        // Reset state, erase_req already high
        #1 chk("rst_busy_dl", busy, 1);
        ioctl_download = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_erasing", erasing, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_core_reset", core_reset, 1);
        chk("rst_load_err", load_err, 0);
        repeat (3) @(posedge clk_sys);
        #1 reset_n = 1'b1;

        // Held erase_req must not look like an edge after reset release
        n = 0; er_seen = 0;
        repeat (300) begin
            @(negedge clk_sys);
            if (erasing) er_seen++;
        end
        chk("no_false_edge", er_seen, 0);
        chk("stretch_done", core_reset, 0);
        erase_req = 1'b0;

        // CPU pass-through when idle
        cpu_a = 16'h1234; cpu_we_n = 1'b0; cpu_do = 8'h5A;
        #1;
        chk("cpu_a", mem_a, 16'h1234);
        chk("cpu_we", mem_we, 1);
        chk("cpu_d", mem_d, 8'h5A);
        chk("cpu_busy", busy, 0);

        // Download table; the CPU keeps requesting a write to show it loses
        cpu_a = 16'hAAAA; cpu_do = 8'h11;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk_sys); #1;
            ioctl_download = 1'b1;
            ioctl_index = vecs[i].idx; ioctl_addr = vecs[i].addr;
            ioctl_dout = vecs[i].dout; ioctl_wr = vecs[i].wr;
            @(negedge clk_sys);
            if (vecs[i].exp_we) chk($sformatf("dl%0d_a", i), mem_a, vecs[i].exp_a);
            chk($sformatf("dl%0d_we", i), mem_we, vecs[i].exp_we);
            chk($sformatf("dl%0d_d", i), mem_d, vecs[i].dout);
            chk($sformatf("dl%0d_err", i), load_err, vecs[i].exp_err);
        end
        chk("dl_core_reset", core_reset, 1);
        @(posedge clk_sys); #1;
        ioctl_wr = 1'b0; ioctl_download = 1'b0; cpu_we_n = 1'b1;
        repeat (2) @(posedge clk_sys);
        @(negedge clk_sys);
        chk("err_sticky", load_err, 1);

        // Erase requested during a download waits in PEND
        @(posedge clk_sys); #1 ioctl_download = 1'b1;
        @(posedge clk_sys); #1 erase_req = 1'b1;
        @(negedge clk_sys);
        chk("err_clr_on_start", load_err, 0);
        @(posedge clk_sys); #1;
        @(negedge clk_sys);
        chk("pend_busy", busy, 1);
        chk("pend_erasing", erasing, 0);
        @(posedge clk_sys); #1 ioctl_download = 1'b0;
        @(negedge clk_sys);
        chk("pend_hold_busy", busy, 1);
        chk("pend_hold_erasing", erasing, 0);
        @(negedge clk_sys);
        chk("erase_start", erasing, 1);
        chk("erase_first_a", mem_a, 16'h7000);

        // Full sweep with a download attempt injected mid-way
        exp_addr = 32'h7000; wcount = 0; bad = 0;
        for (int c = 0; c < 40000 && erasing; c++) begin
            if (mem_we) begin
                if (mem_a !== 16'(exp_addr) || mem_d !== 8'h00) bad++;
                exp_addr++;
                wcount++;
            end
            if (c == 256) begin
                ioctl_download = 1'b1; ioctl_wr = 1'b1; ioctl_index = 8'd1;
                ioctl_addr = '0; ioctl_dout = 8'hEE;
            end
            if (c == 259) begin
                ioctl_download = 1'b0; ioctl_wr = 1'b0;
            end
            @(negedge clk_sys);
        end
        chk("erase_writes", wcount, 32'h9000);
        chk("erase_seq_errors", bad, 0);
        chk("erase_finished", erasing, 0);
        chk("dl_during_erase_err", load_err, 1);
        n = 0;
        while (core_reset && n < 1000) begin
            n++;
            @(negedge clk_sys);
        end
        chk("post_erase_stretch", n, 255);

        // One-clock ext_reset
        n = 0;
        @(posedge clk_sys); #1 ext_reset = 1'b1;
        @(negedge clk_sys);
        if (core_reset) n++;
        @(posedge clk_sys); #1 ext_reset = 1'b0;
        @(negedge clk_sys);
        while (core_reset && n < 1000) begin
            n++;
            @(negedge clk_sys);
        end
        chk("ext_reset_stretch", n, 256);
        cpu_a = 16'h1234; cpu_we_n = 1'b0; cpu_do = 8'h3C;
        #1;
        chk("cpu2_a", mem_a, 16'h1234);
        chk("cpu2_we", mem_we, 1);
        cpu_we_n = 1'b1;

        // Reset mid-erase abandons it; held erase_req does not restart it
        erase_req = 1'b0;
        @(posedge clk_sys); #1 erase_req = 1'b1;
        @(negedge clk_sys);
        n = 0;
        while (!(erasing && mem_a == 16'h8123) && n < 16'h2000) begin
            n++;
            @(negedge clk_sys);
        end
        chk("reached_8123", mem_a, 16'h8123);
        reset_n = 1'b0;
        #1;
        chk("abort_erasing", erasing, 0);
        chk("abort_mem_we", mem_we, 0);
        chk("abort_core_reset", core_reset, 1);
        repeat (3) @(posedge clk_sys);
        #1 reset_n = 1'b1;
        we_seen = 0; er_seen = 0;
        repeat (300) begin
            @(negedge clk_sys);
            if (mem_we) we_seen++;
            if (erasing) er_seen++;
        end
        chk("no_writes_after_abort", we_seen, 0);
        chk("no_restart", er_seen, 0);
        chk("idle_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cart_mem_loader.md
CART_MEM_LOADER -- requirements
Module: cart_mem_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, memory address width.
REQ-002 SHALL have parameter DATA_W, default 8, memory data width.
REQ-003 SHALL have parameter NUM_REGIONS, default 2 (range 1..4), number of ioctl_index load targets.
REQ-004 SHALL have parameter REGION_BASE, default {16'hC000,16'h0000}, flattened NUM_REGIONS*ADDR_W; entry i is the base for index i.
REQ-005 SHALL have parameter REGION_SIZE, default {17'h4000,17'h10000}, flattened NUM_REGIONS*(ADDR_W+1); entry i is the byte limit for index i.
REQ-006 SHALL have parameters ERASE_START (default 16'h7000), ERASE_END (16'hFFFF) and FILL (8'h00), inclusive erase range and fill value.
REQ-007 SHALL have parameter RESET_HOLD, default 255, post-event reset stretch in clocks (8-bit counter).
REQ-008 clk_sys  in  1  system clock; all state on rising edge.
REQ-009 reset_n  in  1  one clock; reset is asynchronous and active-low.
REQ-010 ext_reset  in  1  active-high core reset request (OSD/button/top-level).
REQ-011 ioctl_download, ioctl_wr  in  1 each  download active / write strobe.
REQ-012 ioctl_index  in  8; ioctl_addr  in  25; ioctl_dout  in  DATA_W  download target, offset and data.
REQ-013 erase_req  in  1  level; rising edge starts an erase.
REQ-014 cpu_a  in  ADDR_W; cpu_we_n  in  1; cpu_do  in  DATA_W  CPU-side port.
REQ-015 mem_a  out  ADDR_W; mem_we  out  1; mem_d  out  DATA_W  muxed memory port.
REQ-016 erasing, busy, core_reset, load_err  out  1 each  status.

Function
REQ-017 Port priority SHALL be erase > download > CPU, combinational mux from registered state.
REQ-018 Download path: mem_a = REGION_BASE[idx] + ioctl_addr[ADDR_W-1:0], modulo 2^ADDR_W; mem_d = ioctl_dout; mem_we = ioctl_wr; zero added latency.
REQ-019 Download writes with ioctl_index >= NUM_REGIONS or ioctl_addr >= REGION_SIZE[idx] SHALL be suppressed (mem_we=0) and set load_err, sticky until next download start.
REQ-020 CPU path: mem_a = cpu_a, mem_d = cpu_do, mem_we = ~cpu_we_n, active only when neither erase nor download.
REQ-021 Erase FSM states IDLE, PEND, WRITE, DONE.
REQ-022 IDLE->WRITE on erase_req rising edge with ioctl_download=0; ->PEND if ioctl_download=1.
REQ-023 PEND->WRITE on the first clock with ioctl_download=0; further erase edges in PEND/WRITE are ignored.
REQ-024 WRITE: mem_a = counter (starts ERASE_START), mem_d = FILL, mem_we=1 each clock; counter +1 per clock; at counter==ERASE_END write once more then ->DONE; no wrap past ERASE_END even when ERASE_END = all-ones.
REQ-025 DONE->IDLE after one clock; erasing = 1 in WRITE and DONE only.
REQ-026 A download starting during WRITE SHALL be held off (download writes dropped, load_err set) until erase completes.
REQ-027 busy = erasing | ioctl_download | (state==PEND).
REQ-028 Reset stretch counter SHALL load RESET_HOLD while ext_reset, ioctl_download or erasing is 1, else decrement to 0 and hold.
REQ-029 core_reset = ext_reset | ioctl_download | erasing | (counter != 0), registered-input OR, no glitch from mux.
REQ-030 Erase throughput SHALL be exactly ERASE_END-ERASE_START+1 clocks of mem_we.

Reset
REQ-031 reset_n=0 SHALL asynchronously force FSM=IDLE, erase counter=ERASE_START, stretch counter=RESET_HOLD, load_err=0, edge detector history=1 (no false edge if erase_req held high).
REQ-032 During reset_n=0 outputs SHALL be: erasing=0, mem_we=0 on erase path, core_reset=1, busy=ioctl_download.
REQ-033 Reset asserted mid-erase SHALL abandon the erase; no restart on release without a new erase_req edge.
REQ-034 Release of reset_n SHALL be synchronised internally (2-flop) before stretch counting starts.

Verification
REQ-035 Download index 1, ioctl_addr 0x0000..0x0003, data 0xA0..0xA3 -> mem_we at mem_a 0xC000..0xC003 same data, load_err=0.
REQ-036 Index 1 write at ioctl_addr 0x4000 -> mem_we=0, load_err=1; index 5 -> same.
REQ-037 erase_req rising edge idle -> 0x9000 consecutive writes 0x7000..0xFFFF of 0x00, erasing drops, core_reset stays 1 for 255 more clocks.
REQ-038 erase_req edge during download -> PEND, busy=1; erase begins the clock after ioctl_download falls.
REQ-039 reset_n pulsed low at erase address 0x8123 -> FSM IDLE, no further writes after release, erase_req held high causes no restart.
REQ-040 ext_reset 1 clock then idle -> core_reset high for exactly 1+255 clocks; CPU write with cpu_we_n=0 at 0x1234 passes through when not busy.
